// File: rtl/lut_layer_pkg.sv
// rtl/lut_layer_pkg.sv - shared FSM state type and derived-width helpers for the LUT layer scheduler
package lut_layer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widths never drop below 1 so single-entry configurations stay legal.
  function automatic int idx_w(input int in_w);
    return (in_w > 1) ? $clog2(in_w) : 1;
  endfunction

  function automatic int nid_w(input int n_neurons);
    return (n_neurons > 1) ? $clog2(n_neurons) : 1;
  endfunction

  function automatic int tt_w(input int fan_in);
    return 1 << fan_in;
  endfunction

endpackage

// File: rtl/lut_neuron_eval.sv
// rtl/lut_neuron_eval.sv - gathers FAN_IN activation bits and indexes one neuron's truth table
module lut_neuron_eval #(
  parameter int IN_W   = 64,
  parameter int FAN_IN = 6,
  parameter int IDX_W  = 6,
  parameter int TT_W   = 64
) (
  input  logic [IN_W-1:0]         in_vec,
  input  logic [FAN_IN*IDX_W-1:0] conn,
  input  logic [TT_W-1:0]         tt,
  output logic                    out_bit
);

  logic [FAN_IN-1:0] addr;
  logic [IDX_W-1:0]  idx;

  // Indices past the end of the activation vector read as 0.
  always_comb begin
    addr = '0;
    idx  = '0;
    for (int k = 0; k < FAN_IN; k++) begin
      idx = conn[k*IDX_W +: IDX_W];
      if (int'(idx) < IN_W) begin
        addr[k] = in_vec[idx];
      end
    end
  end

  assign out_bit = tt[addr];

endmodule

// File: rtl/lut_layer_scheduler.sv
// rtl/lut_layer_scheduler.sv - time-multiplexed LUT layer: one shared neuron evaluator, runtime-loaded tables
module lut_layer_scheduler
  import lut_layer_pkg::*;
#(
  parameter int IN_W      = 64,
  parameter int N_NEURONS = 64,
  parameter int FAN_IN    = 6,
  localparam int IDX_W    = idx_w(IN_W),
  localparam int NID_W    = nid_w(N_NEURONS),
  localparam int TT_W     = tt_w(FAN_IN),
  localparam int CONN_W   = FAN_IN * IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_W-1:0]      s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [N_NEURONS-1:0] m_data,
  input  logic                 cfg_we,
  input  logic [NID_W-1:0]     cfg_addr,
  input  logic [TT_W-1:0]      cfg_tt,
  input  logic [CONN_W-1:0]    cfg_conn,
  output logic                 cfg_busy,
  output logic                 cfg_err,
  input  logic                 cfg_err_clr
);

  state_t                 state_q, state_d;
  logic [NID_W-1:0]       cnt_q, cnt_d;
  logic [IN_W-1:0]        in_vec_q, in_vec_d;
  logic [N_NEURONS-1:0]   m_data_q, m_data_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [TT_W-1:0]        tt_q [N_NEURONS];
  logic [TT_W-1:0]        tt_d [N_NEURONS];
  logic [CONN_W-1:0]      conn_q [N_NEURONS];
  logic [CONN_W-1:0]      conn_d [N_NEURONS];
  logic                   last_neuron;
  logic                   eval_bit;

  assign last_neuron = (cnt_q == NID_W'(N_NEURONS - 1));

  lut_neuron_eval #(
    .IN_W   (IN_W),
    .FAN_IN (FAN_IN),
    .IDX_W  (IDX_W),
    .TT_W   (TT_W)
  ) u_eval (
    .in_vec  (in_vec_q),
    .conn    (conn_q[cnt_q]),
    .tt      (tt_q[cnt_q]),
    .out_bit (eval_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      in_vec_q  <= '0;
      m_data_q  <= '0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        tt_q[i]   <= '0;
        conn_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      in_vec_q  <= in_vec_d;
      m_data_q  <= m_data_d;
      cfg_err_q <= cfg_err_d;
      tt_q      <= tt_d;
      conn_q    <= conn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_valid)     state_d = EVAL;
      EVAL:    if (last_neuron) state_d = DONE;
      DONE:    if (m_ready)     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready  = (state_q == IDLE);
    m_valid  = (state_q == DONE);
    cfg_busy = (state_q != IDLE);
  end

  // Config writes only land in IDLE; EVAL starts reading tables one cycle later.
  always_comb begin
    cnt_d     = cnt_q;
    in_vec_d  = in_vec_q;
    m_data_d  = m_data_q;
    cfg_err_d = cfg_err_q;
    tt_d      = tt_q;
    conn_d    = conn_q;
    if (state_q == IDLE) begin
      if (s_valid) begin
        in_vec_d = s_data;
        cnt_d    = '0;
      end
      if (cfg_we && (int'(cfg_addr) < N_NEURONS)) begin
        tt_d[cfg_addr]   = cfg_tt;
        conn_d[cfg_addr] = cfg_conn;
      end
    end else if (cfg_we) begin
      cfg_err_d = 1'b1;
    end
    if (cfg_err_clr) begin
      cfg_err_d = 1'b0;
    end
    if (state_q == EVAL) begin
      m_data_d[cnt_q] = eval_bit;
      cnt_d           = last_neuron ? '0 : cnt_q + NID_W'(1);
    end
  end

  assign m_data  = m_data_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// tb/tb_lut_layer_scheduler.sv - self-checking bench: directed tables, corner sequences, randomized model compare
module tb_lut_layer_scheduler;

  localparam int IN_W = 8;
  localparam int NN   = 4;
  localparam int FI   = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [3:0]  m_data;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [63:0] cfg_tt = '0;
  logic [17:0] cfg_conn = '0;
  logic        cfg_busy;
  logic        cfg_err;
  logic        cfg_err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [63:0] mdl_tt   [NN];
  logic [17:0] mdl_conn [NN];

  typedef struct {
    logic [7:0] din;
    logic [3:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  lut_layer_scheduler #(.IN_W(IN_W), .N_NEURONS(NN), .FAN_IN(FI)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_tt(cfg_tt), .cfg_conn(cfg_conn),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err), .cfg_err_clr(cfg_err_clr)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int n = 0; n < NN; n++) begin
      mdl_tt[n]   = '0;
      mdl_conn[n] = '0;
    end
  endfunction

  // Each neuron: LUT address bit k is activation bit number conn slice k.
  function automatic logic [3:0] model_out(input logic [7:0] v);
    logic [3:0] res;
    int addr, sel;
    res = '0;
    for (int n = 0; n < NN; n++) begin
      addr = 0;
      for (int k = 0; k < FI; k++) begin
        sel = int'(mdl_conn[n][k*3 +: 3]);
        if (sel < IN_W && v[sel]) addr += (1 << k);
      end
      res[n] = mdl_tt[n][addr];
    end
    return res;
  endfunction

  task automatic cfg_write(input int n, input logic [63:0] tt, input logic [17:0] conn);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'(n); cfg_tt = tt; cfg_conn = conn;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    mdl_tt[n] = tt; mdl_conn[n] = conn;
  endtask

  task automatic send(input logic [7:0] d);
    int i;
    @(negedge clk);
    for (i = 0; i < 50 && !s_ready; i++) @(negedge clk);
    if (!s_ready) chk("send_ready_timeout", 64'(s_ready), 64'd1);
    s_valid = 1'b1; s_data = d;
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (m_valid) return;
    end
    chk("m_valid_timeout", 64'(m_valid), 64'd1);
    lat = -1;
  endtask

  task automatic consume();
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
  endtask

  task automatic run(input logic [7:0] d, output logic [3:0] got, output int lat);
    send(d);
    wait_valid(lat);
    got = m_data;
    consume();
  endtask

  logic [3:0] got, held;
  int lat;
  vec_t tbl [5];
  logic [17:0] rc;

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("reset_s_ready", 64'(s_ready), 64'd1);
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_m_data", 64'(m_data), 64'd0);
    chk("reset_cfg_busy", 64'(cfg_busy), 64'd0);
    chk("reset_cfg_err", 64'(cfg_err), 64'd0);

    cfg_write(0, 64'h8000_0000_0000_0000, {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    run(8'h3F, got, lat);
    chk("n0_3f_latency", 64'(lat), 64'd4);
    chk("n0_3f_data", 64'(got), 64'b0001);
    run(8'h3E, got, lat);
    chk("n0_3e_data", 64'(got), 64'b0000);

    // Config write and vector accept in the same IDLE cycle.
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_tt = '1; cfg_conn = '0;
    s_valid = 1'b1; s_data = 8'h3E;
    @(posedge clk);
    #1 cfg_we = 1'b0; s_valid = 1'b0;
    mdl_tt[1] = '1; mdl_conn[1] = '0;
    wait_valid(lat);
    chk("same_cycle_cfg_latency", 64'(lat), 64'd4);
    chk("same_cycle_cfg_data", 64'(m_data), 64'b0010);
    consume();

    for (int n = 0; n < NN; n++) cfg_write(n, 64'hAAAA_AAAA_AAAA_AAAA, 18'(n));
    tbl[0] = '{8'h05, 4'b0101};
    tbl[1] = '{8'h0A, 4'b1010};
    tbl[2] = '{8'hFF, 4'b1111};
    tbl[3] = '{8'hF0, 4'b0000};
    tbl[4] = '{8'h0E, 4'b1110};
    for (int i = 0; i < 5; i++) begin
      run(tbl[i].din, got, lat);
      chk($sformatf("tbl%0d_data", i), 64'(got), 64'(tbl[i].exp));
      chk($sformatf("tbl%0d_model", i), 64'(got), 64'(model_out(tbl[i].din)));
    end

    send(8'h05);
    wait_valid(lat);
    held = m_data;
    chk("bp_first_data", 64'(held), 64'b0101);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold", {m_valid, s_ready, cfg_busy, m_data}, {1'b1, 1'b0, 1'b1, held});
    end
    consume();
    chk("bp_release_s_ready", 64'(s_ready), 64'd1);
    chk("bp_release_m_valid", 64'(m_valid), 64'd0);

    send(8'h0A);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'd3; cfg_tt = '0; cfg_conn = '0;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    chk("drop_err_set", 64'(cfg_err), 64'd1);
    wait_valid(lat);
    chk("drop_inflight_data", 64'(m_data), 64'b1010);
    consume();
    run(8'h0A, got, lat);
    chk("drop_rerun_data", 64'(got), 64'b1010);
    chk("drop_err_sticky", 64'(cfg_err), 64'd1);
    @(negedge clk) cfg_err_clr = 1'b1;
    @(posedge clk);
    #1 cfg_err_clr = 1'b0;
    chk("err_clr", 64'(cfg_err), 64'd0);
    send(8'h0F);
    @(negedge clk);
    cfg_we = 1'b1; cfg_err_clr = 1'b1;
    @(posedge clk);
    #1 cfg_we = 1'b0; cfg_err_clr = 1'b0;
    chk("err_clr_priority", 64'(cfg_err), 64'd0);
    wait_valid(lat);
    chk("clr_priority_data", 64'(m_data), 64'b1111);
    consume();

    for (int it = 0; it < 20; it++) begin
      logic [7:0] d;
      for (int n = 0; n < NN; n++) begin
        for (int k = 0; k < FI; k++) rc[k*3 +: 3] = 3'($urandom_range(0, 7));
        cfg_write(n, {$urandom(), $urandom()}, rc);
      end
      d = 8'($urandom());
      run(d, got, lat);
      chk($sformatf("rand%0d_latency", it), 64'(lat), 64'd4);
      chk($sformatf("rand%0d_data", it), 64'(got), 64'(model_out(d)));
    end

    send(8'hFF);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midreset_m_valid", 64'(m_valid), 64'd0);
    chk("midreset_s_ready", 64'(s_ready), 64'd1);
    chk("midreset_cfg_busy", 64'(cfg_busy), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    model_clear();
    run(8'hFF, got, lat);
    chk("post_reset_latency", 64'(lat), 64'd4);
    chk("post_reset_data", 64'(got), 64'(model_out(8'hFF)));
    chk("post_reset_zero", 64'(got), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
